alu_muldiv_r32: RTL and testbench
=================================

Name: alu_muldiv_r32

Overview:
- Iterative RV32M multiply/divide unit. Sits beside the combinational RV32I ALU in the execute stage.
- Accepts one M-extension instruction with its two operands over a valid/ready handshake, computes over multiple cycles, and returns a registered result over a second valid/ready handshake.
- Operand width is parametrised; divide-by-zero and signed overflow are handled per the RISC-V M spec.

Parameters:
- DATA_WIDTH, 32, operand and result width in bits (even, ≥8).
- INSTR_LENGTH, 32, width of the alu_op instruction word.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept a request.
- alu_op  input  INSTR_LENGTH  full instruction word; uses [6:0], [14:12], [31:25].
- data1  input  DATA_WIDTH  rs1 operand.
- data2  input  DATA_WIDTH  rs2 operand.
- flush  input  1  synchronous kill of any in-flight operation.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- result  output  DATA_WIDTH  operation result.
- busy  output  1  high in CALC or DONE.
- err  output  1  accepted instruction was not an M-extension op.

Behaviour:
- Reset (rst low, async): state IDLE; in_ready=1; out_valid=0; busy=0; err=0; result=0; all internal registers cleared. Reset mid-operation discards the operation; no output afterwards.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch op, operands and signs. Next state:
    - DONE if the op is a special case (see below);
    - otherwise CALC with iteration counter = DATA_WIDTH.
  - CALC: one radix-2 step per cycle.
    - MUL*: shift-add of operand magnitudes into a 2*DATA_WIDTH product.
    - DIV*/REM*: restoring divide of magnitudes.
    - The step on which the counter reaches 0 applies sign correction, loads result, and moves to DONE.
  - DONE: out_valid=1; result and err stable. On out_ready, go to IDLE next edge.
- Latency:
  - Normal op: out_valid high exactly DATA_WIDTH cycles after the accepting edge.
  - Special case: 1 cycle.
  - Back-to-back throughput: one op per DATA_WIDTH+2 cycles (in_ready only in IDLE).
- Decode: valid only when opcode 0110011 and funct7 0000001. funct3 selects:
  - 000 MUL: low half.
  - 001 MULH: signed×signed, high half.
  - 010 MULHSU: signed×unsigned, high half.
  - 011 MULHU: unsigned×unsigned, high half.
  - 100 DIV, 101 DIVU: quotient.
  - 110 REM, 111 REMU: remainder.
- Sign rules:
  - Product negated if operand signs differ (MULHSU: data2 treated as non-negative).
  - Quotient negated if signs differ; remainder takes the dividend's sign (truncating division).
- Special cases (go straight to DONE):
  - Divisor 0: quotient all-ones, remainder = data1 (signed and unsigned).
  - DIV/REM with data1 = most-negative and data2 = all-ones: quotient = data1, remainder = 0.
  - Non-M instruction: result = 0, err = 1.
- flush (sync): from any state, next edge → IDLE; out_valid=0, err=0. Flush wins over a simultaneous in_valid (no accept) and over a simultaneous out_ready.
- Inputs data1/data2/alu_op are don't-care after the accepting edge. result is held unchanged while out_valid=1 and out_ready=0.

Test Plan:
- MUL 7 × 0xFFFFFFFD → result 0xFFFFFFEB; out_valid exactly 32 cycles after accept. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH 0x80000000 × 0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each with 1-cycle latency; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0, 1-cycle latency.
- Hold out_ready=0 for 5 cycles in DONE → out_valid and result stable, in_ready=0; then out_ready=1 → IDLE next edge; back-to-back ops spaced DATA_WIDTH+2 cycles.
- flush at cycle 10 of a DIV → IDLE next edge, no out_valid; rst low mid-CALC → all outputs at reset values immediately; ADD encoding (funct7 0000000) → err=1, result=0.
- DATA_WIDTH=16 instance: MUL 0x00FF × 0x0101 → 0xFFFF, latency 16; DIV 0x8000 / 0xFFFF → 0x8000.

Source files
------------

// File: rtl/alu_muldiv_r32.sv
// Iterative RV32M multiply/divide unit.
// One M-extension op is accepted over in_valid/in_ready, computed one radix-2
// step per cycle on operand magnitudes, sign-corrected on the last step and
// returned as a registered result over out_valid/out_ready.
// Divide-by-zero, signed divide overflow and non-M encodings skip the
// iteration and complete on the accepting edge.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   in_valid/ready  request handshake (ready only while idle)
//   alu_op          instruction word; opcode [6:0], funct3 [14:12], funct7 [31:25]
//   data1, data2    rs1 / rs2 operands
//   flush           synchronous kill of any in-flight or pending operation
//   out_valid/ready result handshake
//   result          operation result, held while out_valid && !out_ready
//   busy            calculating or holding a result
//   err             the accepted instruction was not an M-extension op
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// CALC  | one shift-add / restoring-divide step per cycle
// DONE  | result valid, waiting for out_ready
module alu_muldiv_r32 #(
    parameter int DATA_WIDTH   = 32,
    parameter int INSTR_LENGTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INSTR_LENGTH-1:0] alu_op,
    input  logic [DATA_WIDTH-1:0]   data1,
    input  logic [DATA_WIDTH-1:0]   data2,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   result,
    output logic                    busy,
    output logic                    err
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_next;

    logic [2:0]     f3;
    logic           a_neg, b_neg;
    logic [2*W-1:0] acc;
    logic [W-1:0]   opb;
    logic [CW-1:0]  cnt;

    // Request decode
    logic [2:0] f3_in;
    logic       is_m, is_div, sgn_a_op, sgn_b_op, sign_a, sign_b;
    logic       div_zero, div_ovf, special, accept;
    logic [W-1:0] mag1, mag2, special_res;
    logic       unused_bits;

    assign unused_bits = ^{alu_op[24:15], alu_op[11:7]};

    always_comb begin
        f3_in    = alu_op[14:12];
        is_m     = (alu_op[6:0] == 7'b0110011) && (alu_op[31:25] == 7'b0000001);
        is_div   = f3_in[2];
        sgn_a_op = (f3_in == 3'b001) || (f3_in == 3'b010) || (f3_in == 3'b100) || (f3_in == 3'b110);
        sgn_b_op = (f3_in == 3'b001) || (f3_in == 3'b100) || (f3_in == 3'b110);
        sign_a   = sgn_a_op && data1[W-1];
        sign_b   = sgn_b_op && data2[W-1];
        // two's-complement negate of the most-negative value yields its magnitude as unsigned
        mag1     = sign_a ? -data1 : data1;
        mag2     = sign_b ? -data2 : data2;
        div_zero = is_div && (data2 == '0);
        div_ovf  = is_div && !f3_in[0] && (data1 == {1'b1, {(W-1){1'b0}}}) && (data2 == '1);
        special  = !is_m || div_zero || div_ovf;
        if (!is_m)
            special_res = '0;
        else if (div_zero)
            special_res = f3_in[1] ? data1 : '1;
        else
            special_res = f3_in[1] ? '0 : data1;
        accept   = in_valid && (state == IDLE) && !flush;
    end

    // One iteration step: hi half is the running sum / partial remainder,
    // lo half is the multiplier being shifted out / quotient being shifted in.
    logic [W:0]     mul_sum, div_shift, div_diff;
    logic [2*W-1:0] step_acc, prod_fin;
    logic [W-1:0]   quo_fin, rem_fin, calc_res;

    always_comb begin
        mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opb} : '0);
        div_shift = {acc[2*W-1:W], acc[W-1]};
        div_diff  = div_shift - {1'b0, opb};
        if (f3[2])
            step_acc = div_diff[W] ? {div_shift[W-1:0], acc[W-2:0], 1'b0}
                                   : {div_diff[W-1:0], acc[W-2:0], 1'b1};
        else
            step_acc = {mul_sum, acc[W-1:1]};
        prod_fin = (a_neg ^ b_neg) ? -step_acc : step_acc;
        quo_fin  = (a_neg ^ b_neg) ? -step_acc[W-1:0] : step_acc[W-1:0];
        rem_fin  = a_neg ? -step_acc[2*W-1:W] : step_acc[2*W-1:W];
        case (f3)
            3'b000:          calc_res = prod_fin[W-1:0];
            3'b100, 3'b101:  calc_res = quo_fin;
            3'b110, 3'b111:  calc_res = rem_fin;
            default:         calc_res = prod_fin[2*W-1:W];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept)
                    state_next = special ? DONE : CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == CW'(1))
                    state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush)
            state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f3     <= '0;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
            acc    <= '0;
            opb    <= '0;
            cnt    <= '0;
            result <= '0;
            err    <= 1'b0;
        end else if (flush) begin
            err <= 1'b0;
            cnt <= '0;
        end else if (accept) begin
            f3    <= f3_in;
            a_neg <= sign_a;
            b_neg <= sign_b;
            err   <= !is_m;
            cnt   <= CW'(W);
            if (special)
                result <= special_res;
            // divide shifts the dividend out of lo; multiply shifts the multiplier out of lo
            if (is_div) begin
                acc <= {{W{1'b0}}, mag1};
                opb <= mag2;
            end else begin
                acc <= {{W{1'b0}}, mag2};
                opb <= mag1;
            end
        end else if (state == CALC) begin
            acc <= step_acc;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1))
                result <= calc_res;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_r32.sv
module tb_alu_muldiv_r32;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush, out_valid, out_ready, busy, err;
    logic [31:0] alu_op, data1, data2, result;

    logic        s_in_valid, s_in_ready, s_flush, s_out_valid, s_out_ready, s_busy, s_err;
    logic [31:0] s_alu_op;
    logic [15:0] s_data1, s_data2, s_result;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_muldiv_r32 #(.DATA_WIDTH(32), .INSTR_LENGTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
        .data1(data1), .data2(data2), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy), .err(err)
    );

    alu_muldiv_r32 #(.DATA_WIDTH(16), .INSTR_LENGTH(32)) dut16 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .alu_op(s_alu_op),
        .data1(s_data1), .data2(s_data2), .flush(s_flush), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .result(s_result), .busy(s_busy), .err(s_err)
    );

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd7, 5'd9, f3, 5'd11, 7'b0110011};
    endfunction

    function automatic bit is_mop(input logic [31:0] op);
        return (op[6:0] == 7'b0110011) && (op[31:25] == 7'b0000001);
    endfunction

    function automatic bit is_special(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!is_mop(op)) return 1'b1;
        if (op[14] && b == 32'h0) return 1'b1;
        if ((op[14:12] == 3'd4 || op[14:12] == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1'b1;
        return 1'b0;
    endfunction

    // {err, result} from plain 64-bit arithmetic
    function automatic logic [32:0] ref_op(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        logic [31:0] r;
        bit          ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = 32'h0;
        if (!is_mop(op)) return {1'b1, 32'h0};
        case (op[14:12])
            3'd0: begin p = {32'h0, a} * {32'h0, b}; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'({32'h0, b}); r = p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
            3'd4: begin
                if (b == 32'h0) r = 32'hFFFF_FFFF;
                else if (ovf) r = a;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'h0) r = a;
                else if (ovf) r = 32'h0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 32'h0) ? a : a % b;
        endcase
        return {1'b0, r};
    endfunction

    task automatic chk(input string tag, input string what, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed %0h expected %0h", tag, what, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold, input bit chk_gap);
        logic [32:0] exp;
        int          lat, explat, acc_cyc;
        logic [31:0] held;
        exp    = ref_op(op, a, b);
        explat = is_special(op, a, b) ? 0 : 32;
        @(negedge clk);
        chk(tag, "in_ready_idle", 64'(in_ready), 64'd1);
        alu_op = op; data1 = a; data2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        alu_op   = $urandom; data1 = $urandom; data2 = $urandom;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk(tag, "latency", 64'(lat), 64'(explat));
        chk(tag, "result", 64'(result), 64'(exp[31:0]));
        chk(tag, "err", 64'(err), 64'(exp[32]));
        chk(tag, "busy", 64'(busy), 64'd1);
        if (chk_gap) chk(tag, "gap", 64'(acc_cyc - last_acc), 64'd34);
        last_acc = acc_cyc;
        held = result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk(tag, "hold_result", 64'(result), 64'(held));
            chk(tag, "hold_valid", 64'({out_valid, in_ready}), 64'b10);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk(tag, "release", 64'({in_ready, out_valid, busy}), 64'b100);
    endtask

    task automatic run16(input string tag, input logic [31:0] op, input logic [15:0] a,
                         input logic [15:0] b, input int explat, input logic [15:0] expres);
        int lat;
        @(negedge clk);
        s_alu_op = op; s_data1 = a; s_data2 = b; s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        s_data1 = 16'h0; s_data2 = 16'h0;
        lat = 0;
        while (!s_out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk(tag, "latency", 64'(lat), 64'(explat));
        chk(tag, "result", 64'(s_result), 64'(expres));
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
    endtask

    initial begin
        int          seen;
        logic [31:0] op, a, b;
        rst = 1'b0;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        alu_op = 32'h0; data1 = 32'h0; data2 = 32'h0;
        s_in_valid = 1'b0; s_flush = 1'b0; s_out_ready = 1'b0;
        s_alu_op = 32'h0; s_data1 = 16'h0; s_data2 = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", "ctl", 64'({in_ready, out_valid, busy, err}), 64'b1000);
        chk("reset", "result", 64'(result), 64'd0);
        chk("reset16", "ctl", 64'({s_in_ready, s_out_valid, s_busy, s_err}), 64'b1000);
        @(negedge clk) rst = 1'b1;

        run_op("mul",     mk(7'd1, 3'd0), 32'd7,         32'hFFFF_FFFD, 0, 1'b0);
        run_op("mulhu",   mk(7'd1, 3'd3), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1);
        run_op("mulh",    mk(7'd1, 3'd1), 32'h8000_0000, 32'h8000_0000, 0, 1'b1);
        run_op("mulhsu",  mk(7'd1, 3'd2), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b1);
        run_op("div",     mk(7'd1, 3'd4), 32'hFFFF_FFF9, 32'd2,         0, 1'b0);
        run_op("rem",     mk(7'd1, 3'd6), 32'hFFFF_FFF9, 32'd2,         0, 1'b1);
        run_op("divu",    mk(7'd1, 3'd5), 32'd100,       32'd7,         0, 1'b1);
        run_op("remu",    mk(7'd1, 3'd7), 32'd100,       32'd7,         0, 1'b1);
        run_op("divu0",   mk(7'd1, 3'd5), 32'd5,         32'd0,         0, 1'b0);
        run_op("rem0",    mk(7'd1, 3'd6), 32'd5,         32'd0,         0, 1'b0);
        run_op("div_ovf", mk(7'd1, 3'd4), 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("rem_ovf", mk(7'd1, 3'd6), 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("mulh_neg", mk(7'd1, 3'd1), 32'hFFFF_FFFE, 32'd3,        2, 1'b0);

        // reset mid-calculation after a nonzero result is sitting in the register
        @(negedge clk);
        alu_op = mk(7'd1, 3'd0); data1 = 32'h1234; data2 = 32'h5678; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("rst_mid", "ctl", 64'({in_ready, out_valid, busy, err}), 64'b1000);
        chk("rst_mid", "result", 64'(result), 64'd0);
        @(negedge clk) rst = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid || busy) seen++;
        end
        chk("rst_mid", "quiet", 64'(seen), 64'd0);

        run_op("add", mk(7'd0, 3'd0), 32'd3, 32'd4, 0, 1'b0);

        // flush during a divide, with in_valid also high
        @(negedge clk);
        alu_op = mk(7'd1, 3'd4); data1 = 32'd1000; data2 = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_calc", "ctl", 64'({in_ready, out_valid, busy}), 64'b100);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid || busy) seen++;
        end
        chk("flush_calc", "quiet", 64'(seen), 64'd0);

        // flush in IDLE beats a request
        @(negedge clk);
        alu_op = mk(7'd1, 3'd0); data1 = 32'd2; data2 = 32'd2; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle", "ctl", 64'({in_ready, busy}), 64'b10);

        // flush in DONE beats out_ready and clears err
        @(negedge clk);
        alu_op = mk(7'd0, 3'd0); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("flush_done", "pre", 64'({out_valid, err}), 64'b11);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b0;
        chk("flush_done", "post", 64'({in_ready, out_valid, err}), 64'b100);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) op = $urandom;
            else op = mk(7'd1, 3'($urandom_range(0, 7)));
            case ($urandom_range(0, 7))
                0: a = 32'h8000_0000;
                1: a = $urandom_range(0, 20);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(0, 20);
                default: b = $urandom;
            endcase
            run_op($sformatf("rand%0d", i), op, a, b, $urandom_range(0, 2), 1'b0);
        end

        run16("mul16", mk(7'd1, 3'd0), 16'h00FF, 16'h0101, 16, 16'hFFFF);
        run16("div16_ovf", mk(7'd1, 3'd4), 16'h8000, 16'hFFFF, 0, 16'h8000);
        run16("remu16", mk(7'd1, 3'd7), 16'd1000, 16'd7, 16, 16'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
